// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS.cc BCD stopwatch with run/pause/lap control and tick synchronizer
module stopwatch_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK_50MHz,
    input  logic       reset,
    input  logic       tick_100hz,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] cs0,
    output logic [3:0] cs1,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic [3:0] m0,
    output logic [3:0] m1,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
    localparam logic [5:0][3:0] LIM = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic hist, tick_pulse, inc, zero, latch;
    logic [5:0][3:0] cnt, cnt_nxt, disp;
    logic [6:0] c;
    assign tick_pulse = sync[SYNC_STAGES-1] & ~hist;
    assign inc = tick_pulse && (state == RUN || state == LAP);
    assign zero = clear && (state == IDLE || state == PAUSE);
    assign latch = state == RUN && !start_stop && lap;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = clear ? IDLE : start_stop ? RUN : IDLE;
            RUN:     state_nxt = start_stop ? PAUSE : lap ? LAP : RUN;
            LAP:     state_nxt = start_stop ? PAUSE : lap ? RUN : LAP;
            default: state_nxt = clear ? IDLE : start_stop ? RUN : PAUSE;
        endcase
    end
    // Ripple carry: a digit advances only when all lower digits are at their limit
    always_comb begin
        cnt_nxt = cnt;
        c = '0;
        c[0] = inc;
        for (int i = 0; i < 6; i++) begin
            c[i+1] = c[i] && cnt[i] == LIM[i];
            cnt_nxt[i] = c[i] ? (c[i+1] ? 4'd0 : cnt[i] + 4'd1) : cnt[i];
        end
    end
    always_ff @(posedge CLK_50MHz) begin
        if (reset) begin
            sync     <= '0;
            hist     <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            disp     <= '0;
            overflow <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], tick_100hz};
            hist     <= sync[SYNC_STAGES-1];
            state    <= state_nxt;
            cnt      <= zero ? '0 : cnt_nxt;
            disp     <= latch ? cnt : disp;
            overflow <= zero ? 1'b0 : overflow | c[6];
        end
    end
    assign {m1, m0, s1, s0, cs1, cs0} = state == LAP ? disp : cnt;
    assign running = state == RUN || state == LAP;
    assign lap_active = state == LAP;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed self-checking bench for stopwatch_counter
module tb_stopwatch_counter;
    logic clk = 1'b0;
    logic reset, tick_100hz, start_stop, lap, clear;
    logic [3:0] cs0, cs1, s0, s1, m0, m1;
    logic running, lap_active, overflow;
    logic [23:0] disp;
    int checks = 0;
    int failures = 0;

    stopwatch_counter #(.SYNC_STAGES(2)) dut (
        .CLK_50MHz(clk), .reset(reset), .tick_100hz(tick_100hz),
        .start_stop(start_stop), .lap(lap), .clear(clear),
        .cs0(cs0), .cs1(cs1), .s0(s0), .s1(s1), .m0(m0), .m1(m1),
        .running(running), .lap_active(lap_active), .overflow(overflow)
    );

    always #10 clk = ~clk;
    assign disp = {m1, m0, s1, s0, cs1, cs0};

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic cl);
        start_stop = ss;
        lap = lp;
        clear = cl;
        cyc(1);
        start_stop = 1'b0;
        lap = 1'b0;
        clear = 1'b0;
    endtask

    task automatic ticks(input int n, input int half);
        repeat (n) begin
            tick_100hz = 1'b1;
            cyc(half);
            tick_100hz = 1'b0;
            cyc(half);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        reset = 1'b1;
        tick_100hz = 1'b0;
        start_stop = 1'b0;
        lap = 1'b0;
        clear = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("reset_disp", disp, 24'h000000);
        chk("reset_running", {23'd0, running}, 24'd0);
        chk("reset_lap_active", {23'd0, lap_active}, 24'd0);
        chk("reset_overflow", {23'd0, overflow}, 24'd0);

        // 150 ticks at 20-clock period
        pulse(1, 0, 0);
        chk("start_running", {23'd0, running}, 24'd1);
        ticks(150, 10);
        chk("run150_disp", disp, 24'h000150);
        chk("run150_running", {23'd0, running}, 24'd1);

        // Exact latency of a single tick
        do_reset();
        pulse(1, 0, 0);
        ticks(9, 10);
        chk("pre_lat_disp", disp, 24'h000009);
        tick_100hz = 1'b1;
        cyc(1);
        chk("lat_edge_n", disp, 24'h000009);
        cyc(1);
        chk("lat_edge_n1", disp, 24'h000009);
        cyc(1);
        chk("lat_edge_n2", disp, 24'h000010);
        cyc(7);
        tick_100hz = 1'b0;
        cyc(10);
        chk("lat_settled", disp, 24'h000010);

        // Wrap from 59:59.99 with overflow
        do_reset();
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        dut.cnt = 24'h595999;
        cyc(2);
        chk("preload_disp", disp, 24'h595999);
        pulse(1, 0, 0);
        ticks(1, 10);
        chk("wrap_disp", disp, 24'h000000);
        chk("wrap_overflow", {23'd0, overflow}, 24'd1);
        ticks(1, 10);
        chk("wrap_continues", disp, 24'h000001);
        pulse(1, 0, 0);
        chk("pause_overflow_held", {23'd0, overflow}, 24'd1);
        pulse(0, 0, 1);
        chk("clear_disp", disp, 24'h000000);
        chk("clear_overflow", {23'd0, overflow}, 24'd0);
        chk("clear_idle", {22'd0, running, lap_active}, 24'd0);

        // Lap freeze and release
        do_reset();
        pulse(1, 0, 0);
        ticks(20, 10);
        chk("prelap_disp", disp, 24'h000020);
        pulse(0, 1, 0);
        chk("lap_active_on", {23'd0, lap_active}, 24'd1);
        ticks(30, 10);
        chk("lap_held_disp", disp, 24'h000020);
        chk("lap_running", {23'd0, running}, 24'd1);
        pulse(0, 1, 0);
        chk("lap_active_off", {23'd0, lap_active}, 24'd0);
        chk("lap_release_disp", disp, 24'h000050);

        // Simultaneous start_stop+clear in PAUSE, clear ignored in RUN
        pulse(1, 0, 0);
        chk("pause_disp", disp, 24'h000050);
        chk("pause_not_running", {23'd0, running}, 24'd0);
        pulse(1, 0, 1);
        chk("ss_clear_disp", disp, 24'h000000);
        chk("ss_clear_idle", {23'd0, running}, 24'd0);
        pulse(1, 0, 0);
        ticks(3, 10);
        pulse(0, 0, 1);
        chk("run_clear_ignored", disp, 24'h000003);
        chk("run_clear_running", {23'd0, running}, 24'd1);
        ticks(1, 10);
        chk("run_clear_continue", disp, 24'h000004);

        // Mid-run reset at 00:12.34
        do_reset();
        pulse(1, 0, 0);
        ticks(1234, 2);
        chk("pre_reset_disp", disp, 24'h001234);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("midreset_disp", disp, 24'h000000);
        chk("midreset_flags", {21'd0, running, lap_active, overflow}, 24'd0);
        ticks(5, 10);
        chk("postreset_no_count", disp, 24'h000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on tick_100hz (legal values >= 2).
REQ-002 CLK_50MHz  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the rising edge of CLK_50MHz.
REQ-004 tick_100hz  input  1  100 Hz square wave from the clock divider, asynchronous to CLK_50MHz.
REQ-005 start_stop  input  1  single-cycle pulse, synchronous to CLK_50MHz, toggles run/pause.
REQ-006 lap  input  1  single-cycle pulse, synchronous to CLK_50MHz, toggles display freeze while running.
REQ-007 clear  input  1  single-cycle pulse, synchronous to CLK_50MHz, zeroes the count when stopped.
REQ-008 cs0, cs1  output  4 each  displayed centiseconds, BCD ones/tens, range 0-9.
REQ-009 s0, s1  output  4 each  displayed seconds, BCD ones (0-9) and tens (0-5).
REQ-010 m0, m1  output  4 each  displayed minutes, BCD ones (0-9) and tens (0-5).
REQ-011 running  output  1  high in RUN and LAP states.
REQ-012 lap_active  output  1  high in LAP state.
REQ-013 overflow  output  1  sticky flag, set on wrap from 59:59.99.

Function
REQ-014 tick_100hz SHALL pass through a SYNC_STAGES-deep flop chain plus one history flop; tick_pulse = last sync stage AND NOT history.
REQ-015 With tick_100hz first sampled high at edge N, the live count SHALL increment at edge N+SYNC_STAGES (N+2 for default); exactly one increment per tick_100hz rising edge.
REQ-016 Live count SHALL be a 6-digit BCD cascade MM:SS.cc; a digit's carry increments the next digit in the same edge.
REQ-017 Wrap limits: cs0/cs1/s0/m0 at 9->0; s1 and m1 at 5->0.
REQ-018 Increment from 59:59.99 SHALL give 00:00.00 and set overflow in the same edge; counting continues.
REQ-019 FSM states: IDLE, RUN, PAUSE, LAP; reset state IDLE.
REQ-020 IDLE: start_stop -> RUN; clear -> IDLE (count re-zeroed); lap ignored.
REQ-021 RUN: start_stop -> PAUSE; else lap -> LAP, latching the live count into the display register on that edge; clear ignored.
REQ-022 LAP: start_stop -> PAUSE (display returns to live count); else lap -> RUN (display returns to live count); clear ignored.
REQ-023 PAUSE: clear -> IDLE with count zeroed and overflow cleared; else start_stop -> RUN; lap ignored.
REQ-024 Priority on simultaneous pulses: clear > start_stop > lap where clear is honored; otherwise start_stop > lap.
REQ-025 Increments SHALL occur only when the registered state is RUN or LAP; a tick_pulse in the same cycle as a start_stop from IDLE/PAUSE is not counted, one coincident with start_stop from RUN/LAP is counted.
REQ-026 Outputs SHALL show the latched display register in LAP, otherwise the live count; all outputs registered or decoded directly from registers, no input-to-output combinational path.

Reset
REQ-027 reset SHALL override all inputs and, on that edge, force state IDLE, all digits 0, running 0, lap_active 0, overflow 0, sync and history flops 0, display register 0.
REQ-028 Reset asserted mid-run SHALL take effect on the next edge; no further increment occurs in that edge.
REQ-029 After reset deassertion, a tick_100hz already high SHALL produce a pulse only after SYNC_STAGES edges (treated as a fresh rising edge).

Verification
REQ-030 Reset, start_stop, drive 150 tick_100hz periods (bench period 20 clocks) -> outputs 00:01.50, running=1.
REQ-031 Single tick_100hz rising edge in RUN, count 00:00.09 -> display 00:00.10 exactly at edge N+2, unchanged at N+1.
REQ-032 Preload run to 59:59.99, one more tick -> 00:00.00, overflow=1; pause + clear -> 00:00.00, overflow=0, state IDLE.
REQ-033 RUN at 00:00.20, lap, 30 ticks -> display held 00:00.20, lap_active=1; lap again -> display 00:00.50.
REQ-034 PAUSE with start_stop and clear same cycle -> IDLE, count 0; RUN with clear alone -> ignored, count continues.
REQ-035 reset pulsed for one cycle while RUN at 00:12.34 -> next edge all outputs 0, running=0, subsequent ticks not counted.
